clock_divider_bank: RTL and testbench

Multi-channel programmable clock divider. Generates NUM_CH independent divided square waves from the 50 MHz board clock, with a one-cycle tick per output period. Each channel has a runtime-loadable half-period, glitch-free divisor updates, a per-channel enable and a global phase-align input. It feeds display-scan, blink and debounce timing logic that previously each needed a dedicated fixed divider.

---
 rtl/clock_divider_bank_if.sv | 25 ++
 rtl/clock_divider_bank.sv | 115 +++++++++++
 tb/tb_clock_divider_bank.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/clock_divider_bank_if.sv
// Control, load bus and divided outputs of the clock divider bank.
interface clock_divider_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] Enable;
    logic              Sync;
    logic              LoadEn;
    logic [CH_W-1:0]   LoadCh;
    logic [CNT_W-1:0]  LoadHalf;
    logic [NUM_CH-1:0] CLKOut;
    logic [NUM_CH-1:0] Tick;

    modport master (
        output Enable, Sync, LoadEn, LoadCh, LoadHalf,
        input  CLKOut, Tick
    );

    modport slave (
        input  Enable, Sync, LoadEn, LoadCh, LoadHalf,
        output CLKOut, Tick
    );
endinterface

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider: per-channel 50% duty square wave,
// one-cycle tick per period, glitch-free divisor reloads, global phase align.
module clock_divider_bank #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = 25000000
) (
    input  logic                 CLKIn,
    input  logic                 Reset,
    clock_divider_bank_if.slave  Bus
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ch_state_t;

    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_d [NUM_CH];

    logic [CNT_W-1:0]  count_q [NUM_CH];
    logic [CNT_W-1:0]  count_d [NUM_CH];
    logic [CNT_W-1:0]  half_q  [NUM_CH];
    logic [CNT_W-1:0]  half_d  [NUM_CH];
    logic [CNT_W-1:0]  pend_q  [NUM_CH];
    logic [CNT_W-1:0]  pend_d  [NUM_CH];
    logic [CNT_W-1:0]  cur_cnt [NUM_CH];
    logic [NUM_CH-1:0] pendv_q, pendv_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] ld_hit;
    logic [CNT_W-1:0]  load_val;

    // Channel run state register.
    always_ff @(posedge CLKIn) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (Reset) state_q[i] <= ST_IDLE;
            else       state_q[i] <= state_d[i];
        end
    end

    // Next state follows the per-channel enable.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = Bus.Enable[i] ? ST_RUN : ST_IDLE;
        end
    end

    // Per-channel counter, divisor and output next-value logic.
    // A load landing on a cycle that also applies the divisor (idle, sync or
    // terminal count) bypasses Pend and writes Half directly.
    always_comb begin
        load_val = (Bus.LoadHalf == '0) ? CNT_W'(1) : Bus.LoadHalf;
        ld_hit   = '0;
        pendv_d  = pendv_q;
        clk_d    = clk_q;
        tick_d   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ld_hit[i]  = Bus.LoadEn && (Bus.LoadCh == CH_W'(i));
            cur_cnt[i] = (state_q[i] == ST_IDLE) ? '0 : count_q[i];
            count_d[i] = count_q[i];
            half_d[i]  = half_q[i];
            pend_d[i]  = pend_q[i];

            if ((state_d[i] == ST_IDLE) || Bus.Sync ||
                (cur_cnt[i] == half_q[i] - CNT_W'(1))) begin
                count_d[i] = '0;
                pendv_d[i] = 1'b0;
                if (ld_hit[i])       half_d[i] = load_val;
                else if (pendv_q[i]) half_d[i] = pend_q[i];

                if (state_d[i] == ST_IDLE || Bus.Sync) begin
                    clk_d[i] = 1'b0;
                end else begin
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = ~clk_q[i];
                end
            end else begin
                count_d[i] = cur_cnt[i] + CNT_W'(1);
                if (ld_hit[i]) begin
                    pend_d[i]  = load_val;
                    pendv_d[i] = 1'b1;
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge CLKIn) begin
        if (Reset) begin
            pendv_q <= '0;
            clk_q   <= '0;
            tick_q  <= '0;
        end else begin
            pendv_q <= pendv_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (Reset) begin
                count_q[i] <= '0;
                half_q[i]  <= CNT_W'(DEFAULT_HALF);
                pend_q[i]  <= '0;
            end else begin
                count_q[i] <= count_d[i];
                half_q[i]  <= half_d[i];
                pend_q[i]  <= pend_d[i];
            end
        end
    end

    assign Bus.CLKOut = clk_q;
    assign Bus.Tick   = tick_q;
endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed table-driven bench for clock_divider_bank.
module tb_clock_divider_bank;
    logic CLKIn = 1'b0;
    logic Reset;

    always #5 CLKIn = ~CLKIn;

    clock_divider_bank_if #(.NUM_CH(4), .CNT_W(32)) bus ();
    clock_divider_bank_if #(.NUM_CH(3), .CNT_W(32)) bus3 ();

    clock_divider_bank #(.NUM_CH(4), .CNT_W(32), .DEFAULT_HALF(3)) dut (
        .CLKIn(CLKIn),
        .Reset(Reset),
        .Bus  (bus)
    );

    clock_divider_bank #(.NUM_CH(3), .CNT_W(32), .DEFAULT_HALF(2)) dut3 (
        .CLKIn(CLKIn),
        .Reset(Reset),
        .Bus  (bus3)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic        sync;
        logic        ld;
        logic [1:0]  ch;
        logic [31:0] half;
        logic [3:0]  eclk;
        logic [3:0]  etick;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rst, input logic [3:0] en, input logic sync,
                       input logic ld, input logic [1:0] ch, input logic [31:0] half,
                       input logic [3:0] eclk, input logic [3:0] etick);
        vec_t v;
        v.rst = rst; v.en = en; v.sync = sync; v.ld = ld; v.ch = ch;
        v.half = half; v.eclk = eclk; v.etick = etick;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    initial begin
        // Idle main bus / secondary bus.
        bus.Enable = '0; bus.Sync = 0; bus.LoadEn = 0; bus.LoadCh = '0; bus.LoadHalf = '0;
        bus3.Enable = '0; bus3.Sync = 0; bus3.LoadEn = 0; bus3.LoadCh = '0; bus3.LoadHalf = '0;

        // ch0 at default Half=3
        for (int k = 0; k < 10; k++) begin
            logic c, t;
            c = ((k % 6) >= 2) && ((k % 6) <= 4);
            t = (k % 6) == 2;
            add(0, 4'b0001, 0, 0, 2'd0, 0, {3'b000, c}, {3'b000, t});
        end
        // ch1: Half=5, reload to 2 at Count=1
        add(0, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'd1, 5, 4'b0000, 4'b0000);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0010, 0, 1, 2'd1, 2, 4'b0000, 4'b0000);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0010, 4'b0010);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0010, 4'b0000);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0010, 4'b0010);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0010, 4'b0000);
        add(0, 4'b0010, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        // ch3: LoadHalf=0 while idle -> Half=1
        add(0, 4'b0000, 0, 1, 2'd3, 0, 4'b0000, 4'b0000);
        add(0, 4'b1000, 0, 0, 2'd0, 0, 4'b1000, 4'b1000);
        add(0, 4'b1000, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b1000, 0, 0, 2'd0, 0, 4'b1000, 4'b1000);
        add(0, 4'b1000, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        // ch0, ch2 at Half=4, staggered start, then Sync
        add(0, 4'b0000, 0, 1, 2'd0, 4, 4'b0000, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'd2, 4, 4'b0000, 4'b0000);
        add(0, 4'b0001, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0001, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0001, 4'b0001);
        add(0, 4'b0101, 1, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0101, 4'b0101);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0101, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0101, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0101, 4'b0000);
        // load coincident with ch0 terminal count: Half=2 from next cycle
        add(0, 4'b0101, 0, 1, 2'd0, 2, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0001, 4'b0001);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0001, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0100, 4'b0100);
        // ch2 dropped while high, re-enabled: full Half=4 count
        add(0, 4'b0001, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0001, 4'b0001);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0001, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 0, 0, 2'd0, 0, 4'b0100, 4'b0100);
        // reset mid-run: outputs clear, ch0 back to DEFAULT_HALF=3
        add(1, 4'b0101, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0001, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0001, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0001, 0, 0, 2'd0, 0, 4'b0001, 4'b0001);

        // Reset state with enables asserted: reset wins.
        Reset = 1'b1;
        bus.Enable = 4'b1111;
        bus3.Enable = 3'b111;
        @(posedge CLKIn); #1;
        chk("reset_clk", 0, bus.CLKOut, 4'b0000);
        chk("reset_tick", 0, bus.Tick, 4'b0000);
        chk("reset_clk3", 0, {1'b0, bus3.CLKOut}, 4'b0000);
        bus3.Enable = '0;

        foreach (vecs[n]) begin
            Reset        = vecs[n].rst;
            bus.Enable   = vecs[n].en;
            bus.Sync     = vecs[n].sync;
            bus.LoadEn   = vecs[n].ld;
            bus.LoadCh   = vecs[n].ch;
            bus.LoadHalf = vecs[n].half;
            @(posedge CLKIn); #1;
            chk("clk", n, bus.CLKOut, vecs[n].eclk);
            chk("tick", n, bus.Tick, vecs[n].etick);
        end
        Reset = 1'b0;
        bus.Enable = '0; bus.Sync = 0; bus.LoadEn = 0;

        // Out-of-range LoadCh on a 3-channel bank: Half=2 must persist for 2 periods.
        bus3.Enable   = 3'b111;
        bus3.LoadEn   = 1'b1;
        bus3.LoadCh   = 2'd3;
        bus3.LoadHalf = 32'd1;
        for (int k = 0; k < 8; k++) begin
            logic c, t;
            c = ((k % 4) == 1) || ((k % 4) == 2);
            t = (k % 4) == 1;
            @(posedge CLKIn); #1;
            chk("oor_clk", k, {1'b0, bus3.CLKOut}, {1'b0, {3{c}}});
            chk("oor_tick", k, {1'b0, bus3.Tick}, {1'b0, {3{t}}});
        end
        bus3.LoadEn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
